// File: rtl/sound_addr_gen_if.sv
// sound_addr_gen_if: control/status bundle between game-event logic and the address generator
// master: tick, run_en, trig, stop, mode, start_addr, end_addr out; addr, active, done, wrap in
// slave : the mirror image, used by sound_addr_gen
interface sound_addr_gen_if #(
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2
);
  logic                     tick;
  logic                     run_en;
  logic [NUM_CH-1:0]        trig;
  logic [NUM_CH-1:0]        stop;
  logic [2*NUM_CH-1:0]      mode;
  logic [ADDR_W*NUM_CH-1:0] start_addr;
  logic [ADDR_W*NUM_CH-1:0] end_addr;
  logic [ADDR_W*NUM_CH-1:0] addr;
  logic [NUM_CH-1:0]        active;
  logic [NUM_CH-1:0]        done;
  logic [NUM_CH-1:0]        wrap;
  modport master (output tick, run_en, trig, stop, mode, start_addr, end_addr,
                  input  addr, active, done, wrap);
  modport slave  (input  tick, run_en, trig, stop, mode, start_addr, end_addr,
                  output addr, active, done, wrap);
endinterface

// File: rtl/sound_addr_gen.sv
// sound_addr_gen: per-channel table address walker (one-shot / loop / ping-pong) driven by a slow tick
// clk, reset: clock and synchronous active-high reset
// bus: sound_addr_gen_if slave (channel k uses slice [k*W +: W] of every packed field)
module sound_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2
) (
  input  logic             clk,
  input  logic             reset,
  sound_addr_gen_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2;
  for (genvar g = 0; g < NUM_CH; g++) begin : ch
    logic [1:0]        r_state, w_nstate, r_mode, w_mode;
    logic [ADDR_W-1:0] r_addr, r_start, r_end, w_naddr, w_s, w_e;
    logic              r_done, r_wrap, w_ndone, w_nwrap;
    logic              w_trig, w_stop, w_adv, w_hit, w_at_end, w_at_start, w_one, w_turn;
    assign w_s        = bus.start_addr[g*ADDR_W +: ADDR_W];
    assign w_e        = bus.end_addr[g*ADDR_W +: ADDR_W];
    assign w_mode     = bus.mode[g*2 +: 2];
    assign w_trig     = bus.trig[g];
    assign w_stop     = bus.stop[g];
    assign w_adv      = bus.tick && bus.run_en && r_state != IDLE;
    assign w_hit      = w_adv && !w_stop && !w_trig;
    assign w_at_end   = r_addr >= r_end;
    assign w_at_start = r_addr <= r_start;
    assign w_one      = r_mode == 2'b00;
    // ping-pong with a one-address window degenerates to loop, so it never turns down
    assign w_turn     = r_mode == 2'b10 && r_start != r_end;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= IDLE;
        r_addr  <= '0;
        r_done  <= 1'b0;
        r_wrap  <= 1'b0;
        r_start <= '0;
        r_end   <= '0;
        r_mode  <= 2'b00;
      end else begin
        r_state <= w_nstate;
        r_addr  <= w_naddr;
        r_done  <= w_ndone;
        r_wrap  <= w_nwrap;
        if (w_trig && !w_stop) begin
          r_start <= w_s;
          r_end   <= w_e > w_s ? w_e : w_s;
          r_mode  <= w_mode;
        end
      end
    end
    always_comb begin
      w_nstate = w_stop ? IDLE : w_trig ? UP : !w_adv ? r_state :
                 r_state == UP ? (!w_at_end ? UP : w_one ? IDLE : w_turn ? DOWN : UP) :
                 (w_at_start ? UP : DOWN);
    end
    always_comb begin
      w_naddr = w_stop ? r_addr : w_trig ? w_s : !w_adv ? r_addr :
                r_state == UP ? (!w_at_end ? r_addr + 1'b1 : w_one ? r_addr : w_turn ? r_end - 1'b1 : r_start) :
                (w_at_start ? r_start + 1'b1 : r_addr - 1'b1);
      w_ndone = w_hit && r_state == UP && w_at_end && w_one;
      w_nwrap = w_hit && (r_state == UP ? w_at_end && !w_one && !w_turn : w_at_start);
    end
    assign bus.addr[g*ADDR_W +: ADDR_W] = r_addr;
    assign bus.active[g]                = r_state != IDLE;
    assign bus.done[g]                  = r_done;
    assign bus.wrap[g]                  = r_wrap;
  end
endmodule
